game_flow_fsm: RTL and testbench
================================

# game_flow_fsm

Top-level game-flow controller for the invaders design. It sequences start, play, pause, level-clear, life-lost, win and lose phases. It tracks the current level and the remaining lives. It drives the state code consumed by the display mux, along with the reset and respawn pulses consumed by the sprite, alien and score logic. Button inputs are raw board signals; the block synchronises, debounces and edge-detects them internally.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles before a button level is accepted (≥1).
- DELAY_CYCLES, 50000000: cycles spent in timed phases; button lockout in WIN/LOSE (≥1).
- NUM_LEVELS, 4: waves per game (≥1).
- NUM_LIVES, 3: lives at game start (≥1).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_button, fire_button, pause_button  in  1 each  raw, asynchronous, active-high.
- wave_cleared  in  1  synchronous pulse or level; all aliens destroyed.
- player_hit  in  1  synchronous pulse or level; player destroyed.
- game_state  out  3  current state code.
- level  out  LVL_W=$clog2(NUM_LEVELS) (min 1)  current wave index, 0-based.
- lives  out  LIV_W=$clog2(NUM_LIVES+1)  remaining lives.
- game_reset  out  1  one-cycle full game-logic reset.
- wave_reset  out  1  one-cycle alien-wave reload.
- respawn  out  1  one-cycle player respawn.

## Operation
- State codes: START=0, PLAY=1, PAUSE=2, LEVEL_CLEAR=3, LIFE_LOST=4, WIN=5, LOSE=6.
- Code 7 is illegal. On the next clock it moves to START and pulses game_reset.
- Reset values: game_state=START, level=0, lives=NUM_LIVES, game_reset=1 (held while reset is asserted), wave_reset=0, respawn=0, phase timer=0.
- Each button passes through a button_conditioner. The conditioner produces a one-cycle *_pressed pulse on each accepted 0→1 transition. Releases produce nothing.
- START: on start_pressed, go to PLAY. Pulse game_reset. Set level=0 and lives=NUM_LIVES.
- PLAY: condition priority is player_hit > wave_cleared > pause_pressed.
  - player_hit with lives==1: lives becomes 0 and the state goes to LOSE.
  - player_hit otherwise: lives decrements and the state goes to LIFE_LOST.
  - wave_cleared with level==NUM_LEVELS-1: go to WIN.
  - wave_cleared otherwise: go to LEVEL_CLEAR.
  - pause_pressed: go to PAUSE.
- PAUSE: pause_pressed returns to PLAY. start_pressed goes to START and pulses game_reset. player_hit and wave_cleared are ignored.
- LEVEL_CLEAR: when the timer reaches DELAY_CYCLES-1, increment level, pulse wave_reset and go to PLAY.
- LIFE_LOST: when the timer reaches DELAY_CYCLES-1, pulse respawn and go to PLAY. Level is unchanged.
- WIN: while the timer is below DELAY_CYCLES-1, it counts and every press is discarded; presses are not latched. After that, start_pressed goes to START and pulses game_reset.
- LOSE: same lockout as WIN. After it, start_pressed goes to START with game_reset. fire_pressed restarts directly: go to PLAY, pulse game_reset, level=0, lives=NUM_LIVES. If start_pressed and fire_pressed arrive in the same cycle, start wins.
- The phase timer clears to 0 on every state entry. It saturates at DELAY_CYCLES-1. Its width is $clog2(DELAY_CYCLES+1).
- lives never underflows. level never exceeds NUM_LEVELS-1.
- Asserting reset mid-phase returns every output to its reset value immediately. This includes aborting a running timer.

## Timing
- Button path is a 2-flop synchroniser, then the debounce counter, then the edge detect.
- *_pressed asserts 2+DEBOUNCE_CYCLES+1 cycles after the raw input rises and stays stable.
- Glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- The state register updates on the clock edge after a qualifying condition, and the associated pulse is registered in that same edge. Pulse outputs are high for exactly one cycle.
- Timed phases last exactly DELAY_CYCLES cycles from entry to the exit edge.

## Configuration
- GAME_PAUSE_EN defined: PAUSE state and pause_button are active as described.
- GAME_PAUSE_EN undefined: no PAUSE logic is built and pause_button is ignored. The port remains so the top level is unchanged.

## Structure
- game_pkg holds the state enum/localparams (codes 0–6) and the LVL_W/LIV_W width helper functions.
- One sub-module, button_conditioner, parameterised by DEBOUNCE_CYCLES. It contains the synchroniser, the debounce counter and the rising-edge pulse. It is instantiated three times.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, DELAY_CYCLES=8, NUM_LEVELS=3, NUM_LIVES=2.
- Reset, then start held 10 cycles → start_pressed at cycle 7; next edge game_state=1, game_reset pulses one cycle, level=0, lives=2.
- In PLAY, a 3-cycle start glitch → no pulse; state remains 1.
- wave_cleared at level 0 → state 3 for 8 cycles, then level=1, wave_reset pulses, state 1; repeat to level 2, then wave_cleared → state 5.
- player_hit and wave_cleared in the same cycle with lives=2 → state 4, lives=1; after 8 cycles respawn pulses and state is 1; a second hit → state 6, lives=0.
- In LOSE, fire press during lockout → ignored; fire after 8 cycles → state 1, game_reset pulses, lives=2, level=0.
- Pause with GAME_PAUSE_EN defined: pause → state 2, player_hit ignored, pause again → state 1. With the macro undefined: pause → no change.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state codes and output-width helpers for the invaders game-flow controller.
// Code 7 is deliberately left out of the enum; the FSM treats it as illegal.
package game_pkg;

    typedef enum logic [2:0] {
        ST_START       = 3'd0,
        ST_PLAY        = 3'd1,
        ST_PAUSE       = 3'd2,
        ST_LEVEL_CLEAR = 3'd3,
        ST_LIFE_LOST   = 3'd4,
        ST_WIN         = 3'd5,
        ST_LOSE        = 3'd6
    } state_t;

    // A single-level game still needs a 1-bit level port.
    function automatic int lvl_w(input int num_levels);
        return (num_levels <= 1) ? 1 : $clog2(num_levels);
    endfunction

    function automatic int liv_w(input int num_lives);
        return $clog2(num_lives + 1);
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw board button to one-cycle press pulse: 2-flop synchroniser, debounce counter,
// rising-edge detect. Releases are debounced too but produce no pulse.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pressed
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             stable;
    logic             stable_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync     <= '0;
            cnt      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            pressed  <= 1'b0;
        end else begin
            sync     <= {sync[0], raw};
            stable_d <= stable;
            pressed  <= stable & ~stable_d;
            // The new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                stable <= sync[1];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/game_flow_fsm.sv
// Game-flow controller: sequences start/play/pause/level-clear/life-lost/win/lose phases.
// Define GAME_PAUSE_EN to build the PAUSE state; otherwise pause_button is ignored.
module game_flow_fsm
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DELAY_CYCLES    = 50000000,
    parameter int NUM_LEVELS      = 4,
    parameter int NUM_LIVES       = 3,
    localparam int LVL_W          = lvl_w(NUM_LEVELS),
    localparam int LIV_W          = liv_w(NUM_LIVES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_button,
    input  logic             fire_button,
    input  logic             pause_button,
    input  logic             wave_cleared,
    input  logic             player_hit,
    output logic [2:0]       game_state,
    output logic [LVL_W-1:0] level,
    output logic [LIV_W-1:0] lives,
    output logic             game_reset,
    output logic             wave_reset,
    output logic             respawn
);

    localparam int TMR_W = $clog2(DELAY_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DELAY_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LIV_W-1:0] LIV_FULL = LIV_W'(NUM_LIVES);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             timer_done;
    logic             start_pressed;
    logic             fire_pressed;

    assign game_state = state;
    assign timer_done = (timer == TMR_LAST);

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(clk), .reset(reset), .raw(start_button), .pressed(start_pressed)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire (
        .clk(clk), .reset(reset), .raw(fire_button), .pressed(fire_pressed)
    );

`ifdef GAME_PAUSE_EN
    logic pause_pressed;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk(clk), .reset(reset), .raw(pause_button), .pressed(pause_pressed)
    );
`else
    logic unused_pause;
    assign unused_pause = pause_button;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_START;
            level      <= '0;
            lives      <= LIV_FULL;
            game_reset <= 1'b1;
            wave_reset <= 1'b0;
            respawn    <= 1'b0;
            timer      <= '0;
        end else begin
            game_reset <= 1'b0;
            wave_reset <= 1'b0;
            respawn    <= 1'b0;
            if (!timer_done) timer <= timer + TMR_W'(1);

            // Every transition below also clears the phase timer.
            case (state)
                ST_START: begin
                    if (start_pressed) begin
                        state      <= ST_PLAY;
                        timer      <= '0;
                        game_reset <= 1'b1;
                        level      <= '0;
                        lives      <= LIV_FULL;
                    end
                end
                ST_PLAY: begin
                    if (player_hit) begin
                        timer <= '0;
                        if (lives <= LIV_W'(1)) begin
                            lives <= '0;
                            state <= ST_LOSE;
                        end else begin
                            lives <= lives - LIV_W'(1);
                            state <= ST_LIFE_LOST;
                        end
                    end else if (wave_cleared) begin
                        timer <= '0;
                        state <= (level >= LVL_LAST) ? ST_WIN : ST_LEVEL_CLEAR;
`ifdef GAME_PAUSE_EN
                    end else if (pause_pressed) begin
                        timer <= '0;
                        state <= ST_PAUSE;
`endif
                    end
                end
`ifdef GAME_PAUSE_EN
                ST_PAUSE: begin
                    if (start_pressed) begin
                        state      <= ST_START;
                        timer      <= '0;
                        game_reset <= 1'b1;
                    end else if (pause_pressed) begin
                        state <= ST_PLAY;
                        timer <= '0;
                    end
                end
`endif
                ST_LEVEL_CLEAR: begin
                    if (timer_done) begin
                        state      <= ST_PLAY;
                        timer      <= '0;
                        wave_reset <= 1'b1;
                        if (level < LVL_LAST) level <= level + LVL_W'(1);
                    end
                end
                ST_LIFE_LOST: begin
                    if (timer_done) begin
                        state   <= ST_PLAY;
                        timer   <= '0;
                        respawn <= 1'b1;
                    end
                end
                ST_WIN: begin
                    // Presses during the lockout are dropped, not held over.
                    if (timer_done && start_pressed) begin
                        state      <= ST_START;
                        timer      <= '0;
                        game_reset <= 1'b1;
                    end
                end
                ST_LOSE: begin
                    if (timer_done && start_pressed) begin
                        state      <= ST_START;
                        timer      <= '0;
                        game_reset <= 1'b1;
                    end else if (timer_done && fire_pressed) begin
                        state      <= ST_PLAY;
                        timer      <= '0;
                        game_reset <= 1'b1;
                        level      <= '0;
                        lives      <= LIV_FULL;
                    end
                end
                default: begin
                    state      <= ST_START;
                    timer      <= '0;
                    game_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed bench for game_flow_fsm with DEBOUNCE_CYCLES=4, DELAY_CYCLES=8, NUM_LEVELS=3, NUM_LIVES=2.
// Pause expectations follow GAME_PAUSE_EN.
module tb_game_flow_fsm;

    localparam int DEB = 4;
    localparam int DLY = 8;
    localparam int NLV = 3;
    localparam int NLF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_button = 1'b0;
    logic       fire_button = 1'b0;
    logic       pause_button = 1'b0;
    logic       wave_cleared = 1'b0;
    logic       player_hit = 1'b0;
    logic [2:0] game_state;
    logic [1:0] level;
    logic [1:0] lives;
    logic       game_reset;
    logic       wave_reset;
    logic       respawn;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    game_flow_fsm #(
        .DEBOUNCE_CYCLES(DEB), .DELAY_CYCLES(DLY), .NUM_LEVELS(NLV), .NUM_LIVES(NLF)
    ) dut (
        .clk(clk), .reset(reset),
        .start_button(start_button), .fire_button(fire_button), .pause_button(pause_button),
        .wave_cleared(wave_cleared), .player_hit(player_hit),
        .game_state(game_state), .level(level), .lives(lives),
        .game_reset(game_reset), .wave_reset(wave_reset), .respawn(respawn)
    );

    // Advance n active edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(2);
        vectors++; if (game_state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", game_state); end
        vectors++; if (level !== 2'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", level); end
        vectors++; if (lives !== 2'd2) begin miscompares++; $display("FAIL reset_lives: got %0d expected 2", lives); end
        vectors++; if (game_reset !== 1'b1) begin miscompares++; $display("FAIL reset_game_reset: got %b expected 1", game_reset); end
        vectors++; if ({wave_reset, respawn} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses: got %b expected 00", {wave_reset, respawn}); end
        reset = 1'b0;
        tick(1);
        vectors++; if (game_reset !== 1'b0) begin miscompares++; $display("FAIL reset_release: got %b expected 0", game_reset); end
    endtask

    task automatic test_start;
        start_button = 1'b1;
        tick(7);
        vectors++; if (game_state !== 3'd0) begin miscompares++; $display("FAIL start_latency: got %0d expected 0", game_state); end
        tick(1);
        vectors++; if (game_state !== 3'd1) begin miscompares++; $display("FAIL start_state: got %0d expected 1", game_state); end
        vectors++; if (game_reset !== 1'b1) begin miscompares++; $display("FAIL start_game_reset: got %b expected 1", game_reset); end
        vectors++; if ({level, lives} !== {2'd0, 2'd2}) begin miscompares++; $display("FAIL start_level_lives: got %0d/%0d expected 0/2", level, lives); end
        tick(1);
        vectors++; if (game_reset !== 1'b0) begin miscompares++; $display("FAIL start_pulse_width: got %b expected 0", game_reset); end
        tick(1);
        start_button = 1'b0;
        tick(8);
    endtask

    task automatic test_glitch;
        logic saw;
        saw = 1'b0;
        start_button = 1'b1;
        tick(3);
        start_button = 1'b0;
        repeat (10) begin
            tick(1);
            if (game_reset) saw = 1'b1;
        end
        vectors++; if (game_state !== 3'd1) begin miscompares++; $display("FAIL glitch_state: got %0d expected 1", game_state); end
        vectors++; if (saw !== 1'b0) begin miscompares++; $display("FAIL glitch_pulse: got %b expected 0", saw); end
    endtask

    task automatic test_level_clear;
        for (int lv = 0; lv < 2; lv++) begin
            wave_cleared = 1'b1;
            tick(1);
            wave_cleared = 1'b0;
            vectors++; if (game_state !== 3'd3) begin miscompares++; $display("FAIL clear_enter_%0d: got %0d expected 3", lv, game_state); end
            tick(7);
            vectors++; if (game_state !== 3'd3) begin miscompares++; $display("FAIL clear_hold_%0d: got %0d expected 3", lv, game_state); end
            tick(1);
            vectors++; if (game_state !== 3'd1) begin miscompares++; $display("FAIL clear_exit_%0d: got %0d expected 1", lv, game_state); end
            vectors++; if (level !== 2'(lv + 1)) begin miscompares++; $display("FAIL clear_level_%0d: got %0d expected %0d", lv, level, lv + 1); end
            vectors++; if (wave_reset !== 1'b1) begin miscompares++; $display("FAIL clear_wave_reset_%0d: got %b expected 1", lv, wave_reset); end
            tick(1);
            vectors++; if (wave_reset !== 1'b0) begin miscompares++; $display("FAIL clear_pulse_width_%0d: got %b expected 0", lv, wave_reset); end
        end
        wave_cleared = 1'b1;
        tick(1);
        wave_cleared = 1'b0;
        vectors++; if (game_state !== 3'd5) begin miscompares++; $display("FAIL win_enter: got %0d expected 5", game_state); end
        vectors++; if (level !== 2'd2) begin miscompares++; $display("FAIL win_level: got %0d expected 2", level); end
        tick(8);
        start_button = 1'b1;
        tick(8);
        vectors++; if ({game_state, game_reset} !== {3'd0, 1'b1}) begin miscompares++; $display("FAIL win_exit: got %0d/%b expected 0/1", game_state, game_reset); end
        start_button = 1'b0;
        tick(8);
        start_button = 1'b1;
        tick(8);
        vectors++; if ({game_state, level, lives} !== {3'd1, 2'd0, 2'd2}) begin miscompares++; $display("FAIL win_restart: got %0d/%0d/%0d expected 1/0/2", game_state, level, lives); end
        start_button = 1'b0;
        tick(8);
    endtask

    task automatic test_hit_priority;
        player_hit = 1'b1;
        wave_cleared = 1'b1;
        tick(1);
        player_hit = 1'b0;
        wave_cleared = 1'b0;
        vectors++; if (game_state !== 3'd4) begin miscompares++; $display("FAIL hit_state: got %0d expected 4", game_state); end
        vectors++; if ({level, lives} !== {2'd0, 2'd1}) begin miscompares++; $display("FAIL hit_level_lives: got %0d/%0d expected 0/1", level, lives); end
        tick(7);
        vectors++; if (game_state !== 3'd4) begin miscompares++; $display("FAIL hit_hold: got %0d expected 4", game_state); end
        tick(1);
        vectors++; if ({game_state, respawn} !== {3'd1, 1'b1}) begin miscompares++; $display("FAIL hit_respawn: got %0d/%b expected 1/1", game_state, respawn); end
        tick(1);
        vectors++; if (respawn !== 1'b0) begin miscompares++; $display("FAIL hit_pulse_width: got %b expected 0", respawn); end
    endtask

    task automatic test_lose;
        // The fire press is armed early so its pulse lands inside the LOSE lockout.
        fire_button = 1'b1;
        tick(2);
        player_hit = 1'b1;
        tick(1);
        player_hit = 1'b0;
        vectors++; if ({game_state, lives} !== {3'd6, 2'd0}) begin miscompares++; $display("FAIL lose_enter: got %0d/%0d expected 6/0", game_state, lives); end
        tick(10);
        fire_button = 1'b0;
        tick(8);
        vectors++; if (game_state !== 3'd6) begin miscompares++; $display("FAIL lose_lockout: got %0d expected 6", game_state); end
        fire_button = 1'b1;
        tick(8);
        vectors++; if ({game_state, game_reset} !== {3'd1, 1'b1}) begin miscompares++; $display("FAIL lose_fire_restart: got %0d/%b expected 1/1", game_state, game_reset); end
        vectors++; if ({level, lives} !== {2'd0, 2'd2}) begin miscompares++; $display("FAIL lose_fire_counts: got %0d/%0d expected 0/2", level, lives); end
        fire_button = 1'b0;
        tick(8);
    endtask

    task automatic test_pause;
        pause_button = 1'b1;
        tick(8);
`ifdef GAME_PAUSE_EN
        vectors++; if (game_state !== 3'd2) begin miscompares++; $display("FAIL pause_enter: got %0d expected 2", game_state); end
        pause_button = 1'b0;
        tick(8);
        player_hit = 1'b1;
        tick(1);
        player_hit = 1'b0;
        vectors++; if ({game_state, lives} !== {3'd2, 2'd2}) begin miscompares++; $display("FAIL pause_hit_ignored: got %0d/%0d expected 2/2", game_state, lives); end
        pause_button = 1'b1;
        tick(8);
        vectors++; if (game_state !== 3'd1) begin miscompares++; $display("FAIL pause_exit: got %0d expected 1", game_state); end
`else
        vectors++; if (game_state !== 3'd1) begin miscompares++; $display("FAIL pause_disabled: got %0d expected 1", game_state); end
`endif
        pause_button = 1'b0;
        tick(8);
        vectors++; if (game_state !== 3'd1) begin miscompares++; $display("FAIL pause_settle: got %0d expected 1", game_state); end
    endtask

    task automatic test_reset_mid;
        player_hit = 1'b1;
        tick(1);
        player_hit = 1'b0;
        tick(8);
        wave_cleared = 1'b1;
        tick(1);
        wave_cleared = 1'b0;
        tick(8);
        vectors++; if ({game_state, level, lives} !== {3'd1, 2'd1, 2'd1}) begin miscompares++; $display("FAIL mid_setup: got %0d/%0d/%0d expected 1/1/1", game_state, level, lives); end
        wave_cleared = 1'b1;
        tick(1);
        wave_cleared = 1'b0;
        tick(3);
        reset = 1'b1;
        #1;
        vectors++; if ({game_state, level, lives} !== {3'd0, 2'd0, 2'd2}) begin miscompares++; $display("FAIL mid_reset_regs: got %0d/%0d/%0d expected 0/0/2", game_state, level, lives); end
        vectors++; if ({game_reset, wave_reset, respawn} !== 3'b100) begin miscompares++; $display("FAIL mid_reset_pulses: got %b expected 100", {game_reset, wave_reset, respawn}); end
        tick(1);
        reset = 1'b0;
        tick(10);
        vectors++; if ({game_state, wave_reset} !== {3'd0, 1'b0}) begin miscompares++; $display("FAIL mid_reset_after: got %0d/%b expected 0/0", game_state, wave_reset); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_glitch();
        test_level_clear();
        test_hit_priority();
        test_lose();
        test_pause();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
